ttn_scale_cntr_bank: RTL and testbench



---
 rtl/ttn_pll_pkg.sv | 57 +++++
 rtl/ttn_scale_cntr_ch.sv | 125 ++++++++++++
 rtl/ttn_scale_cntr_bank.sv | 96 +++++++++
 tb/tb_ttn_scale_cntr_bank.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttn_pll_pkg.sv
// Shared types for the PLL scale-down counter bank: output modes,
// per-channel states, the write config bundle and tick-count helpers.
package ttn_pll_pkg;

    // Config fields are carried at a fixed maximum width and zero-extended;
    // the bank's own CNT_W/PH_W must not exceed CFG_W.
    localparam int CFG_W = 16;
    localparam int XW    = CFG_W + 2;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_BYPASS = 2'd1,
        MODE_EVEN   = 2'd2,
        MODE_ODD    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_DELAY,
        ST_RUN,
        ST_BYPASS
    } ch_st_e;

    typedef struct packed {
        mode_e            mode;
        logic [CFG_W-1:0] high;
        logic [CFG_W-1:0] low;
        logic [CFG_W-1:0] init;
        logic [CFG_W-1:0] ph;
    } cfg_t;

    function automatic logic is_div(input mode_e m);
        return (m == MODE_EVEN) || (m == MODE_ODD);
    endfunction

    // High phase length in ticks: 2*high, one less in ODD mode.
    function automatic logic [XW-1:0] hi_ticks(input cfg_t c);
        logic [XW-1:0] h2;
        h2 = {1'b0, c.high, 1'b0};
        return (c.mode == MODE_ODD) ? h2 - XW'(1) : h2;
    endfunction

    // Low phase length in ticks: 2*low, one more in ODD mode.
    function automatic logic [XW-1:0] lo_ticks(input cfg_t c);
        logic [XW-1:0] l2;
        l2 = {1'b0, c.low, 1'b0};
        return (c.mode == MODE_ODD) ? l2 + XW'(1) : l2;
    endfunction

    // Start delay in ticks: 2*(init-1) + ph, with init of 0 read as 1.
    function automatic logic [XW-1:0] dly_ticks(input cfg_t c);
        logic [CFG_W-1:0] im1;
        im1 = (c.init == '0) ? '0 : c.init - CFG_W'(1);
        return {1'b0, im1, 1'b0} + XW'(c.ph);
    endfunction

endpackage

// File: rtl/ttn_scale_cntr_ch.sv
// One scale-down channel: active config, state, tick counter, registered cout.
// Ports: clk/reset; ld_i+cfg_i load a config; cout_o, running_o, busy_o, bnd_o.
module ttn_scale_cntr_ch
    import ttn_pll_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ld_i,
    input  cfg_t cfg_i,
    output logic cout_o,
    output logic running_o,
    output logic busy_o,
    output logic bnd_o
);

    localparam int CW = CNT_W + 2;

    ch_st_e        st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] hm1_q, hm1_d;
    logic [CW-1:0] lm1_q, lm1_d;
    logic          cout_q, cout_d;
    logic          run_q, run_d;
    logic [CW-1:0] ld_hm1, ld_lm1, ld_dly;

    assign ld_hm1 = CW'(hi_ticks(cfg_i) - XW'(1));
    assign ld_lm1 = CW'(lo_ticks(cfg_i) - XW'(1));
    assign ld_dly = CW'(dly_ticks(cfg_i));

    assign busy_o    = (st_q == ST_RUN) || (st_q == ST_BYPASS);
    // Boundary: the edge at which cout goes 0 -> 1 while running.
    assign bnd_o     = !cout_q &&
                       ((st_q == ST_RUN && cnt_q == '0) || st_q == ST_BYPASS);
    assign cout_o    = cout_q;
    assign running_o = run_q;

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        cout_d = cout_q;
        hm1_d  = hm1_q;
        lm1_d  = lm1_q;
        unique case (st_q)
            ST_OFF: begin
                cout_d = 1'b0;
                cnt_d  = '0;
            end
            ST_DELAY: begin
                if (cnt_q == '0) begin
                    st_d   = ST_RUN;
                    cout_d = 1'b1;
                    cnt_d  = hm1_q;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (cout_q) begin
                    cout_d = 1'b0;
                    cnt_d  = lm1_q;
                end else begin
                    cout_d = 1'b1;
                    cnt_d  = hm1_q;
                end
            end
            ST_BYPASS: cout_d = !cout_q;
            default: ;
        endcase
        // A load while busy only arrives on a boundary, so the new period
        // starts high immediately; an idle channel (re)enters its delay.
        if (ld_i) begin
            hm1_d = ld_hm1;
            lm1_d = ld_lm1;
            cnt_d = '0;
            unique case (cfg_i.mode)
                MODE_EVEN, MODE_ODD: begin
                    if (busy_o) begin
                        st_d   = ST_RUN;
                        cout_d = 1'b1;
                        cnt_d  = ld_hm1;
                    end else begin
                        st_d   = ST_DELAY;
                        cout_d = 1'b0;
                        cnt_d  = ld_dly;
                    end
                end
                MODE_BYPASS: begin
                    st_d   = ST_BYPASS;
                    cout_d = busy_o;
                end
                default: begin
                    st_d   = ST_OFF;
                    cout_d = 1'b0;
                end
            endcase
        end
        // running rises with the first high output, not with state entry.
        run_d = (st_d == ST_RUN) ||
                (st_d == ST_BYPASS &&
                 (cout_d || (st_q == ST_BYPASS && run_q)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q   <= ST_OFF;
            cnt_q  <= '0;
            hm1_q  <= '0;
            lm1_q  <= '0;
            cout_q <= 1'b0;
            run_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            hm1_q  <= hm1_d;
            lm1_q  <= lm1_d;
            cout_q <= cout_d;
            run_q  <= run_d;
        end
    end

endmodule

// File: rtl/ttn_scale_cntr_bank.sv
// Bank of PLL scale-down counters with a valid/ready config write port.
// Ports: clk/reset; cfg_* write request, cfg_ready, cfg_err; cout, running.
module ttn_scale_cntr_bank
    import ttn_pll_pkg::*;
#(
    parameter int NUM_CH = 10,
    parameter int CNT_W  = 8,
    parameter int PH_W   = 3,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_high,
    input  logic [CNT_W-1:0]  cfg_low,
    input  logic [CNT_W-1:0]  cfg_init,
    input  logic [PH_W-1:0]   cfg_ph,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] cout,
    output logic [NUM_CH-1:0] running
);

    cfg_t              wr_cfg, pcfg_q, ld_cfg;
    logic              pend_q;
    logic [CH_W-1:0]   pch_q;
    logic              err_q;
    logic              acc, bad, tgt_busy, pend_hit;
    logic [NUM_CH-1:0] ld, busy, bnd;

    always_comb begin
        wr_cfg      = '0;
        wr_cfg.mode = mode_e'(cfg_mode);
        wr_cfg.high = CFG_W'(cfg_high);
        wr_cfg.low  = CFG_W'(cfg_low);
        wr_cfg.init = CFG_W'(cfg_init);
        wr_cfg.ph   = CFG_W'(cfg_ph);
    end

    assign cfg_ready = !pend_q;
    assign cfg_err   = err_q;
    assign acc       = cfg_valid && cfg_ready && !reset;
    assign bad       = (int'(cfg_ch) >= NUM_CH) ||
                       (is_div(wr_cfg.mode) &&
                        (cfg_high == '0 || cfg_low == '0));
    // Only one of these is live at a time: accepts need an empty slot.
    assign ld_cfg    = pend_q ? pcfg_q : wr_cfg;

    always_comb begin
        tgt_busy = 1'b0;
        pend_hit = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(cfg_ch) == i) tgt_busy = busy[i];
            if (int'(pch_q) == i)  pend_hit = bnd[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= 1'b0;
            pcfg_q <= '0;
            pch_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= acc && bad;
            if (pend_q && pend_hit) begin
                pend_q <= 1'b0;
            end else if (acc && !bad && tgt_busy) begin
                pend_q <= 1'b1;
                pcfg_q <= wr_cfg;
                pch_q  <= cfg_ch;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ld[i] = (acc && !bad && !busy[i] && int'(cfg_ch) == i) ||
                       (pend_q && bnd[i] && int'(pch_q) == i);

        ttn_scale_cntr_ch #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .ld_i     (ld[i]),
            .cfg_i    (ld_cfg),
            .cout_o   (cout[i]),
            .running_o(running[i]),
            .busy_o   (busy[i]),
            .bnd_o    (bnd[i])
        );
    end

endmodule

// File: tb/tb_ttn_scale_cntr_bank.sv
// Randomized scoreboard bench for ttn_scale_cntr_bank.
// A time-based channel model predicts every cycle's outputs.
module tb_ttn_scale_cntr_bank;

    localparam int NUM_CH = 10;
    localparam int CNT_W  = 8;
    localparam int PH_W   = 3;
    localparam int CHW    = $clog2(NUM_CH);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [CHW-1:0]    cfg_ch = '0;
    logic [1:0]        cfg_mode = '0;
    logic [CNT_W-1:0]  cfg_high = '0;
    logic [CNT_W-1:0]  cfg_low = '0;
    logic [CNT_W-1:0]  cfg_init = '0;
    logic [PH_W-1:0]   cfg_ph = '0;
    logic              cfg_err;
    logic [NUM_CH-1:0] cout;
    logic [NUM_CH-1:0] running;

    ttn_scale_cntr_bank #(
        .NUM_CH(NUM_CH),
        .CNT_W (CNT_W),
        .PH_W  (PH_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_mode (cfg_mode),
        .cfg_high (cfg_high),
        .cfg_low  (cfg_low),
        .cfg_init (cfg_init),
        .cfg_ph   (cfg_ph),
        .cfg_err  (cfg_err),
        .cout     (cout),
        .running  (running)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_CH-1:0] cout;
        logic [NUM_CH-1:0] running;
        logic              rdy;
        logic              err;
        longint            t;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Model: kind 0 = off, 1 = divided, 2 = bypass. t0 is the time of the
    // first high output; before it the channel is still delaying.
    int     kind[NUM_CH];
    longint t0[NUM_CH];
    int     hh[NUM_CH];
    int     ll[NUM_CH];
    bit     pend;
    int     pch, pm, ph_h, ph_l;
    longint pb;
    bit     err_m;
    longint t = 0;

    function automatic void set_ch(int ch, int m, int h, int l, longint ts);
        if (m == 0) begin
            kind[ch] = 0;
        end else if (m == 1) begin
            kind[ch] = 2;
            t0[ch]   = ts;
        end else begin
            kind[ch] = 1;
            t0[ch]   = ts;
            hh[ch]   = (m == 2) ? 2 * h : 2 * h - 1;
            ll[ch]   = (m == 2) ? 2 * l : 2 * l + 1;
        end
    endfunction

    function automatic bit is_busy(int ch, longint tt);
        if (kind[ch] == 1) return (tt - 1 >= t0[ch]);
        if (kind[ch] == 2) return (tt - 1 >= t0[ch] - 1);
        return 1'b0;
    endfunction

    initial begin
        for (int i = 0; i < NUM_CH; i++) kind[i] = 0;
        pend  = 1'b0;
        err_m = 1'b0;
        forever begin
            exp_t   e;
            bit     ppre;
            int     ch, m, h, l, in, ph, per;
            @(posedge clk);
            t++;
            if (reset) begin
                for (int i = 0; i < NUM_CH; i++) kind[i] = 0;
                pend  = 1'b0;
                err_m = 1'b0;
            end else begin
                ppre  = pend;
                err_m = 1'b0;
                if (pend && t == pb) begin
                    set_ch(pch, pm, ph_h, ph_l, t);
                    pend = 1'b0;
                end
                if (cfg_valid && !ppre) begin
                    ch = int'(cfg_ch);
                    m  = int'(cfg_mode);
                    h  = int'(cfg_high);
                    l  = int'(cfg_low);
                    in = int'(cfg_init);
                    ph = int'(cfg_ph);
                    if (in == 0) in = 1;
                    if (ch >= NUM_CH || (m >= 2 && (h == 0 || l == 0))) begin
                        err_m = 1'b1;
                    end else if (is_busy(ch, t)) begin
                        per  = (kind[ch] == 1) ? hh[ch] + ll[ch] : 2;
                        pend = 1'b1;
                        pch  = ch;
                        pm   = m;
                        ph_h = h;
                        ph_l = l;
                        pb   = t0[ch] + ((t - t0[ch]) / per + 1) * per;
                    end else if (m >= 2) begin
                        set_ch(ch, m, h, l, t + 2 * (in - 1) + ph + 1);
                    end else begin
                        set_ch(ch, m, h, l, t + 1);
                    end
                end
            end
            e.cout    = '0;
            e.running = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (kind[i] != 0 && t >= t0[i]) begin
                    e.running[i] = 1'b1;
                    if (kind[i] == 1)
                        e.cout[i] = ((t - t0[i]) % (hh[i] + ll[i])) < hh[i];
                    else
                        e.cout[i] = ((t - t0[i]) % 2) == 0;
                end
            end
            e.rdy = !pend;
            e.err = err_m;
            e.t   = t;
            q.push_back(e);
        end
    end

    function automatic void chk(string nm, longint tt,
                                logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got=%0h want=%0h", nm, tt, act, exp);
        end
    endfunction

    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("cout", e.t, 32'(cout), 32'(e.cout));
                chk("running", e.t, 32'(running), 32'(e.running));
                chk("cfg_ready", e.t, 32'(cfg_ready), 32'(e.rdy));
                chk("cfg_err", e.t, 32'(cfg_err), 32'(e.err));
            end
        end
    end

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(int ch, int m, int h, int l, int in, int ph);
        int n;
        cfg_valid = 1'b1;
        cfg_ch    = CHW'(ch);
        cfg_mode  = 2'(m);
        cfg_high  = CNT_W'(h);
        cfg_low   = CNT_W'(l);
        cfg_init  = CNT_W'(in);
        cfg_ph    = PH_W'(ph);
        n = 0;
        while (!cfg_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL wr_accept_timeout ch=%0d got=no_ready want=ready", ch);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        reset = 1'b0;
        wr(0, 2, 2, 2, 1, 0);
        idle(20);
        wr(1, 3, 3, 2, 2, 3);
        idle(30);
        wr(0, 2, 1, 1, 1, 0);
        idle(20);
        wr(3, 2, 0, 2, 1, 0);
        idle(2);
        wr(NUM_CH, 2, 2, 2, 1, 0);
        idle(3);
        wr(2, 1, 0, 0, 0, 0);
        idle(7);
        wr(2, 0, 0, 0, 0, 0);
        idle(6);
        wr(9, 2, 255, 255, 0, 7);
        wr(8, 3, 1, 1, 255, 7);
        idle(600);
        wr(9, 0, 0, 0, 0, 0);
        idle(4);
        cfg_valid = 1'b1;
        cfg_ch    = CHW'(4);
        cfg_mode  = 2'd2;
        cfg_high  = CNT_W'(1);
        cfg_low   = CNT_W'(1);
        cfg_init  = CNT_W'(1);
        reset     = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        cfg_valid = 1'b0;
        idle(5);
        for (int k = 0; k < 250; k++) begin
            if ($urandom_range(0, 99) < 3) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end else begin
                wr($urandom_range(0, NUM_CH + 1), $urandom_range(0, 3),
                   $urandom_range(0, 4), $urandom_range(0, 4),
                   $urandom_range(0, 3), $urandom_range(0, 7));
            end
            idle($urandom_range(0, 12));
        end
        idle(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
